spi_xfer_sequencer: RTL and testbench
=====================================

// Module: spi_xfer_sequencer
// PURPOSE
//  System-clock controller that sequences the SPI slave datapath (shift register, address latch, data memory, MISO tri-state).
//  Synchronizes raw cs/sclk/mosi pins and detects sclk edges.
//  Issues one-cycle strobes per transaction: address byte, then one read or one write data byte.
//  Replaces clocking the control logic directly from sclk; requires clk >= 8x sclk.
// PARAMETERS
//  WIDTH        8  bits per SPI byte; also the bit-counter terminal count
//  SYNC_STAGES  2  flops in each pin synchronizer (>= 2)
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  cs_pin       in   1      raw chip select, active low (1 = deselected)
//  sclk_pin     in   1      raw SPI clock, mode 0
//  mosi_pin     in   1      raw MOSI
//  sr_pout      in   WIDTH  shift-register parallel out; sr_pout[0] = r/w bit (1 = read)
//  sr_sin       out  1      synchronized MOSI, shift-register serial in
//  sr_shift_en  out  1      1-cycle shift strobe
//  sr_load      out  1      1-cycle parallel load of shift register from memory
//  addr_wren    out  1      1-cycle address-latch enable
//  dm_wren      out  1      1-cycle data-memory write enable
//  miso_en      out  1      MISO driver enable, level
//  busy         out  1      high in any state other than IDLE
//  xfer_done    out  1      1-cycle pulse on entry to DONE
//  abort        out  1      see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE, bit counter=0, synchronizer flops=1 (cs, sclk) / 0 (mosi); all outputs 0.
//  Pin sync: SYNC_STAGES flops, then one edge-detect flop.
//    A pin edge produces sclk_rise/sclk_fall exactly SYNC_STAGES+1 clk after it (3 at default).
//    sr_sin = synchronized mosi; it is sampled with the same delay as sclk, so setup is preserved.
//  Bit counter: log2(WIDTH)+1 bits. Cleared on every state change. Increments on each counted edge.
//    Terminal count = WIDTH; the counter never wraps.
//  States and transitions:
//    IDLE      : cs_s==0 -> ADDR.
//    ADDR      : each sclk_rise -> sr_shift_en pulse, cnt++. Same cycle cnt reaches WIDTH -> DECODE.
//    DECODE    : addr_wren=1 for 1 cycle. sr_pout[0]==1 -> READ_LOAD, else -> WR_SHIFT.
//    READ_LOAD : sr_load=1 for 1 cycle (memory read data valid 1 cycle after addr_wren); miso_en=1 from here.
//                -> RD_SHIFT.
//    RD_SHIFT  : miso_en=1. Each sclk_fall -> sr_shift_en pulse, cnt++.
//                Slave MISO is valid before the first rising edge, so sclk_fall #1 presents bit 6.
//                cnt==WIDTH -> DONE.
//    WR_SHIFT  : miso_en=0. Each sclk_rise -> sr_shift_en, cnt++. cnt==WIDTH -> WR_COMMIT.
//    WR_COMMIT : dm_wren=1 for 1 cycle -> DONE.
//    DONE      : xfer_done pulse on entry; miso_en=0.
//                Further sclk edges are ignored, with no strobes. Stays until cs_s==1 -> IDLE.
//  cs_s==1 in any state (checked first, every cycle) -> IDLE next cycle; counter cleared.
//    Strobes are suppressed in that cycle, even if an sclk edge coincides.
//  dm_wren never asserts unless all WIDTH write bits were received.
//  Rising and falling edges are mutually exclusive per cycle.
//    sclk edges in DECODE, READ_LOAD or WR_COMMIT are a protocol violation; they are ignored and not counted.
//  Async reset mid-transaction: immediate return to reset values; no strobe completes.
//  Latency: last address rising edge on the pin -> addr_wren = SYNC_STAGES+2 clk.
// CONFIGURATION
//  SPI_CS_ABORT_EN defined:
//    cs_s rising while in ADDR..WR_COMMIT -> abort=1 for exactly 1 cycle, coincident with the IDLE transition.
//    No abort from IDLE or DONE.
//  SPI_CS_ABORT_EN undefined: abort tied to 0; no extra logic.
// TESTING
//  1 Reset: hold reset_n=0, toggle pins -> all outputs 0, busy=0; release -> still IDLE while cs_pin=1.
//  2 Write: cs low, shift 0x54 (addr 0x2A, w), then 0xC3 ->
//    8 shift strobes, addr_wren once, 8 shift strobes, dm_wren once, xfer_done once.
//    Memory[0x2A]=0xC3.
//  3 Read: preload memory[0x2A]=0x96, send 0x55 ->
//    addr_wren, sr_load next cycle, miso_en=1; MISO bits 1,0,0,1,0,1,1,0 on 8 clocks; xfer_done; miso_en=0 in DONE.
//  4 Abort: cs high after 5 write-data bits ->
//    IDLE, no dm_wren, memory unchanged; abort pulse=1 iff SPI_CS_ABORT_EN.
//  5 Extra clocks: 4 sclk cycles in DONE -> no strobes.
//    cs high then low -> new transaction decodes correctly.
//  6 Coincidence: cs_pin rises on the same clk as an sclk rise -> no sr_shift_en, IDLE next cycle.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: system-clock sequencer for an SPI slave datapath (pin sync, sclk edge detect, per-byte strobes).
// Define SPI_CS_ABORT_EN to get a one-cycle abort pulse when chip select ends a transfer before completion.
module spi_xfer_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs_pin,
    input  logic             sclk_pin,
    input  logic             mosi_pin,
    input  logic [WIDTH-1:0] sr_pout,
    output logic             sr_sin,
    output logic             sr_shift_en,
    output logic             sr_load,
    output logic             addr_wren,
    output logic             dm_wren,
    output logic             miso_en,
    output logic             busy,
    output logic             xfer_done,
    output logic             abort
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DECODE, S_READ_LOAD, S_RD_SHIFT, S_WR_SHIFT, S_WR_COMMIT, S_DONE
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_sclk_d, r_mosi_d;
    logic                   r_shift, r_load, r_awren, r_dwren, r_miso_en, r_done;
    logic                   w_cs_s, w_sclk_s, w_rise, w_fall, w_full;
    logic                   w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b1;
            r_mosi_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            r_sclk_d    <= w_sclk_s;
            r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;
    assign w_fall   = ~w_sclk_s & r_sclk_d;
    assign w_full   = r_cnt == C_FULL;
    assign w_unused = ^sr_pout[WIDTH-1:1];

    // mosi gets the same extra stage as sclk so the shift samples the bit seen at the detected edge
    assign sr_sin      = r_mosi_d;
    assign sr_shift_en = r_shift;
    assign sr_load     = r_load;
    assign addr_wren   = r_awren;
    assign dm_wren     = r_dwren;
    assign miso_en     = r_miso_en;
    assign xfer_done   = r_done;
    assign busy        = r_state != S_IDLE;

`ifdef SPI_CS_ABORT_EN
    logic r_abort;
    assign abort = r_abort;
`else
    assign abort = 1'b0;
`endif

    // Strobes are registered with the transition into the state that owns them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= 1'b0;
            r_load    <= 1'b0;
            r_awren   <= 1'b0;
            r_dwren   <= 1'b0;
            r_miso_en <= 1'b0;
            r_done    <= 1'b0;
`ifdef SPI_CS_ABORT_EN
            r_abort   <= 1'b0;
`endif
        end else begin
            r_shift <= 1'b0;
            r_load  <= 1'b0;
            r_awren <= 1'b0;
            r_dwren <= 1'b0;
            r_done  <= 1'b0;
`ifdef SPI_CS_ABORT_EN
            r_abort <= w_cs_s && r_state != S_IDLE && r_state != S_DONE;
`endif
            if (w_cs_s) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_miso_en <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ADDR;
                        r_cnt   <= '0;
                    end
                    S_ADDR: begin
                        if (w_full) begin
                            r_state <= S_DECODE;
                            r_cnt   <= '0;
                            r_awren <= 1'b1;
                        end else if (w_rise) begin
                            r_shift <= 1'b1;
                            r_cnt   <= r_cnt + C_ONE;
                        end
                    end
                    S_DECODE: begin
                        r_cnt <= '0;
                        if (sr_pout[0]) begin
                            r_state   <= S_READ_LOAD;
                            r_load    <= 1'b1;
                            r_miso_en <= 1'b1;
                        end else begin
                            r_state <= S_WR_SHIFT;
                        end
                    end
                    S_READ_LOAD: begin
                        r_state <= S_RD_SHIFT;
                        r_cnt   <= '0;
                    end
                    S_RD_SHIFT: begin
                        if (w_full) begin
                            r_state   <= S_DONE;
                            r_cnt     <= '0;
                            r_done    <= 1'b1;
                            r_miso_en <= 1'b0;
                        end else if (w_fall) begin
                            r_shift <= 1'b1;
                            r_cnt   <= r_cnt + C_ONE;
                        end
                    end
                    S_WR_SHIFT: begin
                        if (w_full) begin
                            r_state <= S_WR_COMMIT;
                            r_cnt   <= '0;
                            r_dwren <= 1'b1;
                        end else if (w_rise) begin
                            r_shift <= 1'b1;
                            r_cnt   <= r_cnt + C_ONE;
                        end
                    end
                    S_WR_COMMIT: begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end
                    S_DONE: r_state <= S_DONE;
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: drives SPI mode-0 transactions against a behavioural datapath and scoreboards the strobes.
module tb_spi_xfer_sequencer;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset_n, cs_pin, sclk_pin, mosi_pin;
    logic [7:0] tb_sr = 8'h00;
    logic [6:0] tb_addr = 7'h00;
    logic [7:0] mem [128] = '{default: 8'h00};
    logic       sr_sin, sr_shift_en, sr_load, addr_wren, dm_wren, miso_en, busy, xfer_done, abort;
    logic [8:0] outs;

    int n_vec = 0, n_err = 0, cyc = 0;
    int n_shift = 0, n_aw = 0, n_dw = 0, n_done = 0, n_abort = 0;
    int s_shift, s_aw, s_dw, s_done, s_abort;
    int t_rise = 0, t_aw = 0, t_sh = 0, t_ld = 0;
    logic [7:0]  rd_bits = 8'h00;
    logic        rd_active = 1'b0;
    logic [23:0] sb_q [$];

    spi_xfer_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cs_pin(cs_pin), .sclk_pin(sclk_pin), .mosi_pin(mosi_pin),
        .sr_pout(tb_sr), .sr_sin(sr_sin), .sr_shift_en(sr_shift_en), .sr_load(sr_load),
        .addr_wren(addr_wren), .dm_wren(dm_wren), .miso_en(miso_en), .busy(busy),
        .xfer_done(xfer_done), .abort(abort)
    );

    assign outs = {sr_sin, sr_shift_en, sr_load, addr_wren, dm_wren, miso_en, busy, xfer_done, abort};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (sr_load) tb_sr <= mem[tb_addr];
        else if (sr_shift_en) tb_sr <= {tb_sr[6:0], sr_sin};
        if (addr_wren) tb_addr <= tb_sr[7:1];
        if (dm_wren) mem[tb_addr] <= tb_sr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ev(input logic [7:0] k, input logic [7:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    task automatic sb_chk(input string tag, input logic [23:0] obs);
        if (sb_q.size() == 0) chk(tag, {8'd0, obs}, 32'hFFFF_FFFF);
        else chk(tag, {8'd0, obs}, {8'd0, sb_q.pop_front()});
    endtask

    always @(negedge clk) begin
        if (sr_shift_en) begin
            n_shift++;
            t_sh = cyc;
            if (miso_en) rd_bits = {rd_bits[6:0], tb_sr[7]};
        end
        if (sr_load) begin
            t_ld = cyc;
            rd_active = 1'b1;
        end
        if (addr_wren) begin
            n_aw++;
            t_aw = cyc;
            sb_chk("addr_latch", ev(8'd1, {1'b0, tb_sr[7:1]}, {7'd0, tb_sr[0]}));
        end
        if (dm_wren) begin
            n_dw++;
            sb_chk("mem_write", ev(8'd2, {1'b0, tb_addr}, tb_sr));
        end
        if (xfer_done) begin
            n_done++;
            if (rd_active) sb_chk("read_byte", ev(8'd3, {1'b0, tb_addr}, rd_bits));
            rd_active = 1'b0;
        end
        if (abort) begin
            n_abort++;
            chk("abort_idle", {31'd0, busy}, 32'd0);
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_shift = n_shift; s_aw = n_aw; s_dw = n_dw; s_done = n_done; s_abort = n_abort;
    endtask

    task automatic sclk_bit(input logic b);
        mosi_pin = b;
        wclk(H);
        sclk_pin = 1'b1;
        t_rise = cyc;
        wclk(H);
        sclk_pin = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sclk_bit(b[i]);
        wclk(H);
    endtask

    task automatic cs_low();
        cs_pin = 1'b0;
        wclk(H);
    endtask

    task automatic cs_high();
        wclk(H);
        cs_pin = 1'b1;
        wclk(H);
    endtask

    initial begin
        int exp_abort;
`ifdef SPI_CS_ABORT_EN
        exp_abort = 1;
`else
        exp_abort = 0;
`endif
        reset_n = 1'b0; cs_pin = 1'b1; sclk_pin = 1'b0; mosi_pin = 1'b0;
        wclk(2);
        for (int i = 0; i < 4; i++) begin
            sclk_pin = ~sclk_pin; mosi_pin = ~mosi_pin; cs_pin = ~cs_pin;
            wclk(2);
        end
        chk("reset_outs", {23'd0, outs}, 32'd0);
        cs_pin = 1'b1; sclk_pin = 1'b0; mosi_pin = 1'b0;
        wclk(2);
        reset_n = 1'b1;
        wclk(10);
        chk("idle_outs", {23'd0, outs}, 32'd0);

        sb_q.push_back(ev(8'd1, 8'h2A, 8'h00));
        sb_q.push_back(ev(8'd2, 8'h2A, 8'hC3));
        snap();
        cs_low();
        spi_byte(8'h54);
        chk("shift_latency", t_sh - t_rise, 3);
        chk("awren_latency", t_aw - t_rise, 4);
        spi_byte(8'hC3);
        wclk(8);
        chk("wr_shifts", n_shift - s_shift, 16);
        chk("wr_awren", n_aw - s_aw, 1);
        chk("wr_dmwren", n_dw - s_dw, 1);
        chk("wr_done", n_done - s_done, 1);
        chk("wr_mem", {24'd0, mem[7'h2A]}, 32'hC3);
        chk("wr_done_state", {30'd0, busy, miso_en}, 32'd2);

        snap();
        for (int i = 0; i < 4; i++) sclk_bit(1'b1);
        wclk(8);
        chk("extra_shifts", n_shift - s_shift, 0);
        chk("extra_done", n_done - s_done, 0);
        cs_high();
        chk("done_no_abort", n_abort - s_abort, 0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);

        sb_q.push_back(ev(8'd1, 8'h2A, 8'h00));
        sb_q.push_back(ev(8'd2, 8'h2A, 8'h96));
        cs_low();
        spi_byte(8'h54);
        spi_byte(8'h96);
        wclk(8);
        cs_high();
        chk("rewrite_mem", {24'd0, mem[7'h2A]}, 32'h96);

        sb_q.push_back(ev(8'd1, 8'h2A, 8'h01));
        sb_q.push_back(ev(8'd3, 8'h2A, 8'h96));
        snap();
        cs_low();
        spi_byte(8'h55);
        chk("load_after_awren", t_ld - t_aw, 1);
        chk("rd_miso_en", {31'd0, miso_en}, 32'd1);
        spi_byte(8'h00);
        wclk(8);
        chk("rd_shifts", n_shift - s_shift, 16);
        chk("rd_done", n_done - s_done, 1);
        chk("rd_no_dmwren", n_dw - s_dw, 0);
        chk("rd_done_state", {30'd0, busy, miso_en}, 32'd2);
        cs_high();

        sb_q.push_back(ev(8'd1, 8'h2A, 8'h00));
        snap();
        cs_low();
        spi_byte(8'h54);
        for (int i = 0; i < 5; i++) sclk_bit(1'b1);
        wclk(H);
        cs_pin = 1'b1;
        wclk(8);
        chk("abort_shifts", n_shift - s_shift, 13);
        chk("abort_no_dmwren", n_dw - s_dw, 0);
        chk("abort_no_done", n_done - s_done, 0);
        chk("abort_pulse", n_abort - s_abort, exp_abort);
        chk("abort_mem", {24'd0, mem[7'h2A]}, 32'h96);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);

        snap();
        cs_low();
        for (int i = 0; i < 3; i++) sclk_bit(1'b0);
        mosi_pin = 1'b1;
        wclk(H);
        cs_pin = 1'b1;
        sclk_pin = 1'b1;
        wclk(2);
        chk("coinc_busy_before", {31'd0, busy}, 32'd1);
        wclk(1);
        chk("coinc_busy_after", {31'd0, busy}, 32'd0);
        wclk(6);
        chk("coinc_shifts", n_shift - s_shift, 3);
        chk("coinc_abort", n_abort - s_abort, exp_abort);
        sclk_pin = 1'b0;
        wclk(8);

        cs_low();
        for (int i = 0; i < 3; i++) sclk_bit(1'b1);
        wclk(2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {23'd0, outs}, 32'd0);
        cs_pin = 1'b1;
        wclk(2);
        reset_n = 1'b1;
        wclk(6);
        chk("post_reset_idle", {31'd0, busy}, 32'd0);

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
